uart_fifo_periph: RTL and testbench

- Single-channel, CPU-mapped UART peripheral with parametrised RX/TX FIFOs and a runtime-programmable 16-bit baud divisor.
- Adds sticky overrun and framing-error flags, FIFO level readback and a maskable interrupt.
- Sits on the Z80 I/O bus next to the existing serial ports; it is the baseline for future serial channels.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_sync_fifo.sv | 52 +++++
 rtl/uart_fifo_periph.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_periph.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART FIFO peripheral: register map, status/irq bit
// positions, shifter state encodings and small helpers used by the register file.
package uart_pkg;

   localparam logic [3:0] ADDR_DATA   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h1;
   localparam logic [3:0] ADDR_DIV_LO = 4'h2;
   localparam logic [3:0] ADDR_DIV_HI = 4'h3;
   localparam logic [3:0] ADDR_IRQ_EN = 4'h4;
   localparam logic [3:0] ADDR_RXCNT  = 4'h5;
   localparam logic [3:0] ADDR_TXCNT  = 4'h6;

   localparam int ST_TX_NOT_FULL  = 0;
   localparam int ST_RX_NOT_EMPTY = 1;
   localparam int ST_TX_IDLE      = 2;
   localparam int ST_RX_OVERRUN   = 3;
   localparam int ST_FRAMING_ERR  = 4;

   localparam int IE_RX_NOT_EMPTY = 0;
   localparam int IE_TX_NOT_FULL  = 1;
   localparam int IE_ERROR        = 2;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // A 256-deep FIFO can report 256, which does not fit the 8-bit bus; saturate.
   function automatic logic [7:0] level_byte(input logic [8:0] level);
      return (level > 9'd255) ? 8'hFF : level[7:0];
   endfunction

   function automatic logic [15:0] clamp_div(input logic [15:0] value,
                                             input logic [15:0] min_div);
      return (value < min_div) ? min_div : value;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push while full is accepted only
// when a pop frees the slot in the same cycle.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_fifo_periph.sv
// CPU-mapped UART with RX/TX FIFOs, programmable divisor, sticky error flags
// and a maskable level interrupt.
//
// TX state | meaning
// IDLE     | line high, waiting for a byte in the TX FIFO
// START    | driving start bit (0) for DIV+1 clk
// DATA     | shifting 8 bits LSB first, DIV+1 clk each
// STOP     | driving stop bit (1); chains straight into START if more data
//
// RX state | meaning
// IDLE     | waiting for a falling edge on the synchronised line
// START    | half-bit wait, then confirm start bit or reject as glitch
// DATA     | sampling 8 bits at bit centres
// STOP     | sampling stop bit; on framing error holds until the line is high
module uart_fifo_periph
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int DEFAULT_DIV = 218,
   parameter int MIN_DIV     = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_cs,
   input  logic       R_W_n,
   input  logic [3:0] reg_addr,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic       irq
);

   localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] DEF_DIV16  = 16'(DEFAULT_DIV);
   localparam logic [15:0] MIN_DIV16  = 16'(MIN_DIV);

   logic          cs_q;
   logic          strobe;
   logic          wr_stb;
   logic          rd_stb;
   logic          status_clr;

   logic [15:0]   div;
   logic [2:0]    irq_en;
   logic          rx_overrun;
   logic          framing_err;
   logic [7:0]    status;

   logic          tx_push;
   logic          tx_pop;
   logic [7:0]    tx_dout;
   logic          tx_full;
   logic          tx_empty;
   logic [CW-1:0] tx_count;
   logic          tx_idle;

   logic          rx_push;
   logic          rx_pop;
   logic [7:0]    rx_dout;
   logic          rx_full;
   logic          rx_empty;
   logic [CW-1:0] rx_count;

   // Bus access: one side effect per rising edge of chip select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cs_q <= 1'b0;
      else        cs_q <= uart_cs;
   end

   assign strobe     = uart_cs & ~cs_q;
   assign wr_stb     = strobe & ~R_W_n;
   assign rd_stb     = strobe & R_W_n;
   assign tx_push    = wr_stb & (reg_addr == ADDR_DATA);
   assign rx_pop     = rd_stb & (reg_addr == ADDR_DATA);
   assign status_clr = rd_stb & (reg_addr == ADDR_STATUS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div    <= DEF_DIV16;
         irq_en <= 3'b000;
      end else if (wr_stb) begin
         case (reg_addr)
            ADDR_DIV_LO: div    <= clamp_div({div[15:8], data_i}, MIN_DIV16);
            ADDR_DIV_HI: div    <= clamp_div({data_i, div[7:0]}, MIN_DIV16);
            ADDR_IRQ_EN: irq_en <= data_i[2:0];
            default:     ;
         endcase
      end
   end

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (data_i),
      .dout  (tx_dout),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   // ---------------------------------------------------------------- TX
   tx_state_t   tx_state, tx_state_d;
   logic [15:0] tx_cnt, tx_cnt_d;
   logic [15:0] tx_div, tx_div_d;
   logic [7:0]  tx_shift, tx_shift_d;
   logic [2:0]  tx_bit, tx_bit_d;
   logic        tx_line, tx_line_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= DEF_DIV16;
         tx_shift <= '0;
         tx_bit   <= '0;
         tx_line  <= 1'b1;
      end else begin
         tx_state <= tx_state_d;
         tx_cnt   <= tx_cnt_d;
         tx_div   <= tx_div_d;
         tx_shift <= tx_shift_d;
         tx_bit   <= tx_bit_d;
         tx_line  <= tx_line_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state;
      tx_cnt_d   = tx_cnt;
      tx_div_d   = tx_div;
      tx_shift_d = tx_shift;
      tx_bit_d   = tx_bit;
      tx_line_d  = tx_line;
      tx_pop     = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            tx_line_d = 1'b1;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_div_d   = div;
               tx_cnt_d   = div;
               tx_shift_d = tx_dout;
               tx_line_d  = 1'b0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt == 16'd0) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = tx_div;
               tx_bit_d   = 3'd0;
               tx_line_d  = tx_shift[0];
            end else begin
               tx_cnt_d = tx_cnt - 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_cnt == 16'd0) begin
               tx_cnt_d = tx_div;
               if (tx_bit == 3'd7) begin
                  tx_state_d = TX_STOP;
                  tx_line_d  = 1'b1;
               end else begin
                  tx_shift_d = {1'b0, tx_shift[7:1]};
                  tx_line_d  = tx_shift[1];
                  tx_bit_d   = tx_bit + 3'd1;
               end
            end else begin
               tx_cnt_d = tx_cnt - 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_cnt == 16'd0) begin
               // Chain the next frame with no idle gap if data is waiting.
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_div_d   = div;
                  tx_cnt_d   = div;
                  tx_shift_d = tx_dout;
                  tx_line_d  = 1'b0;
                  tx_state_d = TX_START;
               end else begin
                  tx_line_d  = 1'b1;
                  tx_state_d = TX_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt - 16'd1;
            end
         end
         default: begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_IDLE;
         end
      endcase
   end

   assign uart_tx = tx_line;
   assign tx_idle = tx_empty & (tx_state == TX_IDLE);

   // ---------------------------------------------------------------- RX
   logic        rx_meta, rx_sync, rx_prev;
   rx_state_t   rx_state, rx_state_d;
   logic [15:0] rx_cnt, rx_cnt_d;
   logic [15:0] rx_div, rx_div_d;
   logic [7:0]  rx_shift, rx_shift_d;
   logic [2:0]  rx_bit, rx_bit_d;
   logic        rx_brk, rx_brk_d;
   logic        rx_done;
   logic        fe_set;
   logic        ovr_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= DEF_DIV16;
         rx_shift <= '0;
         rx_bit   <= '0;
         rx_brk   <= 1'b0;
      end else begin
         rx_state <= rx_state_d;
         rx_cnt   <= rx_cnt_d;
         rx_div   <= rx_div_d;
         rx_shift <= rx_shift_d;
         rx_bit   <= rx_bit_d;
         rx_brk   <= rx_brk_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state;
      rx_cnt_d   = rx_cnt;
      rx_div_d   = rx_div;
      rx_shift_d = rx_shift;
      rx_bit_d   = rx_bit;
      rx_brk_d   = rx_brk;
      rx_done    = 1'b0;
      fe_set     = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_sync) begin
               rx_div_d   = div;
               rx_cnt_d   = div >> 1;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt == 16'd0) begin
               if (rx_sync) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_cnt_d   = rx_div;
                  rx_bit_d   = 3'd0;
                  rx_state_d = RX_DATA;
               end
            end else begin
               rx_cnt_d = rx_cnt - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt == 16'd0) begin
               rx_shift_d = {rx_sync, rx_shift[7:1]};
               rx_cnt_d   = rx_div;
               if (rx_bit == 3'd7) rx_state_d = RX_STOP;
               else                rx_bit_d   = rx_bit + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt - 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_brk) begin
               if (rx_sync) begin
                  rx_brk_d   = 1'b0;
                  rx_state_d = RX_IDLE;
               end
            end else if (rx_cnt == 16'd0) begin
               if (rx_sync) begin
                  rx_done    = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  fe_set   = 1'b1;
                  rx_brk_d = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt - 16'd1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   assign rx_push = rx_done & (~rx_full | rx_pop);
   assign ovr_set = rx_done & rx_full & ~rx_pop;

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_shift),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   // A set in the same cycle as the clearing STATUS read wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_overrun  <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         if (ovr_set)         rx_overrun  <= 1'b1;
         else if (status_clr) rx_overrun  <= 1'b0;
         if (fe_set)          framing_err <= 1'b1;
         else if (status_clr) framing_err <= 1'b0;
      end
   end

   always_comb begin
      status                  = 8'h00;
      status[ST_TX_NOT_FULL]  = ~tx_full;
      status[ST_RX_NOT_EMPTY] = ~rx_empty;
      status[ST_TX_IDLE]      = tx_idle;
      status[ST_RX_OVERRUN]   = rx_overrun;
      status[ST_FRAMING_ERR]  = framing_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq <= 1'b0;
      else        irq <= (irq_en[IE_RX_NOT_EMPTY] & ~rx_empty)
                       | (irq_en[IE_TX_NOT_FULL]  & ~tx_full)
                       | (irq_en[IE_ERROR]        & (rx_overrun | framing_err));
   end

   always_comb begin
      data_o = 8'h00;
      case (reg_addr)
         ADDR_DATA:   data_o = rx_empty ? 8'h00 : rx_dout;
         ADDR_STATUS: data_o = status;
         ADDR_DIV_LO: data_o = div[7:0];
         ADDR_DIV_HI: data_o = div[15:8];
         ADDR_IRQ_EN: data_o = {5'b00000, irq_en};
         ADDR_RXCNT:  data_o = level_byte(9'(rx_count));
         ADDR_TXCNT:  data_o = level_byte(9'(tx_count));
         default:     data_o = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Self-checking bench for uart_fifo_periph: bus-level stimulus, a serial line
// monitor/driver and queue-based expectations derived from the UART frame rules.
module tb_uart_fifo_periph;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_cs = 1'b0;
   logic       R_W_n = 1'b1;
   logic [3:0] reg_addr = 4'h0;
   logic [7:0] data_i = 8'h00;
   wire  [7:0] data_o;
   wire        uart_tx;
   wire        irq;
   logic       loop_en = 1'b0;
   logic       rx_drv = 1'b1;
   wire        uart_rx_w = loop_en ? uart_tx : rx_drv;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;

   uart_fifo_periph dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .uart_cs  (uart_cs),
      .R_W_n    (R_W_n),
      .reg_addr (reg_addr),
      .data_i   (data_i),
      .data_o   (data_o),
      .uart_rx  (uart_rx_w),
      .uart_tx  (uart_tx),
      .irq      (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Line monitor: decodes every frame seen on uart_tx at the current divisor.
   int         mon_div = 218;
   logic [7:0] mon_q[$];
   logic       mon_stop_q[$];
   longint     mon_t[$];
   logic       mon_prev = 1'b1;

   initial begin : monitor
      logic [7:0] b;
      longint     t0;
      int         d;
      forever begin
         @(negedge clk);
         if (rst_n && mon_prev && uart_tx === 1'b0) begin
            t0 = cyc;
            d  = mon_div;
            repeat ((d + 1) / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (d + 1) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (d + 1) @(negedge clk);
            mon_q.push_back(b);
            mon_stop_q.push_back(uart_tx);
            mon_t.push_back(t0);
         end
         mon_prev = uart_tx;
      end
   end

   task automatic mon_clear();
      mon_q.delete();
      mon_stop_q.delete();
      mon_t.delete();
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      uart_cs = 1'b1; R_W_n = 1'b0; reg_addr = a; data_i = d;
      @(negedge clk);
      uart_cs = 1'b0; R_W_n = 1'b1;
   endtask

   task automatic bus_read(input logic [3:0] a, input int hold, output logic [7:0] d);
      @(negedge clk);
      uart_cs = 1'b1; R_W_n = 1'b1; reg_addr = a;
      #1 d = data_o;
      repeat (hold) @(negedge clk);
      uart_cs = 1'b0;
   endtask

   task automatic set_div(input int d);
      logic [15:0] v;
      v = 16'(d);
      bus_write(ADDR_DIV_HI, v[15:8]);
      bus_write(ADDR_DIV_LO, v[7:0]);
      mon_div = d;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (d + 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (d + 1) @(negedge clk);
      end
      rx_drv = stop;
      repeat (d + 1) @(negedge clk);
      rx_drv = 1'b1;
   endtask

   task automatic wait_rx_count(input int n, input int budget, output bit ok);
      logic [7:0] v;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         bus_read(ADDR_RXCNT, 1, v);
         if (v == 8'(n)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [3:0] ra [9];
      logic [7:0] rv [9];
      logic [7:0] v;
      ra = '{ADDR_DATA, ADDR_STATUS, ADDR_DIV_LO, ADDR_DIV_HI, ADDR_IRQ_EN,
             ADDR_RXCNT, ADDR_TXCNT, 4'h7, 4'hF};
      rv = '{8'h00, 8'h05, 8'hDA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bus_read(ra[i], 1, v);
         checks++;
         if (v !== rv[i]) begin
            errors++;
            $display("FAIL reset_reg[%h]: got %h expected %h", ra[i], v, rv[i]);
         end
      end
   endtask

   task automatic test_tx_frame();
      logic [9:0] fr;
      logic [7:0] v;
      fr = {1'b1, 8'h55, 1'b0};
      mon_clear();
      bus_write(ADDR_DATA, 8'h55);
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_latency_n1: got %b expected 1", uart_tx); end
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b0) begin errors++; $display("FAIL tx_latency_n2: got %b expected 0", uart_tx); end
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (uart_tx !== fr[k]) begin errors++; $display("FAIL tx_bit%0d_first: got %b expected %b", k, uart_tx, fr[k]); end
         repeat (218) @(negedge clk);
         checks++;
         if (uart_tx !== fr[k]) begin errors++; $display("FAIL tx_bit%0d_last: got %b expected %b", k, uart_tx, fr[k]); end
         @(negedge clk);
      end
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_after_stop: got %b expected 1", uart_tx); end
      bus_read(ADDR_STATUS, 1, v);
      checks++;
      if (v[ST_TX_IDLE] !== 1'b1) begin errors++; $display("FAIL tx_idle_after_frame: got %b expected 1", v[ST_TX_IDLE]); end
      checks++;
      if (mon_q.size() != 1 || mon_q[0] !== 8'h55) begin
         errors++;
         $display("FAIL tx_monitor_byte: got %0d frames expected one 0x55", mon_q.size());
      end
   endtask

   task automatic test_tx_fill();
      logic [7:0] v;
      int         i;
      set_div(20);
      mon_clear();
      bus_write(ADDR_DATA, 8'h40);
      for (int b = 8'h41; b <= 8'h50; b++) bus_write(ADDR_DATA, 8'(b));
      bus_write(ADDR_DATA, 8'hFF);
      bus_read(ADDR_TXCNT, 1, v);
      checks++;
      if (v !== 8'd16) begin errors++; $display("FAIL tx_count_peak: got %0d expected 16", v); end
      bus_read(ADDR_STATUS, 1, v);
      checks++;
      if (v[ST_TX_NOT_FULL] !== 1'b0) begin errors++; $display("FAIL tx_full_flag: got %b expected 0", v[ST_TX_NOT_FULL]); end
      i = 0;
      while (i < 17 * 210 + 400 && mon_q.size() < 17) begin
         @(negedge clk);
         i++;
      end
      repeat (300) @(negedge clk);
      checks++;
      if (mon_q.size() != 17) begin errors++; $display("FAIL tx_frame_count: got %0d expected 17", mon_q.size()); end
      for (int k = 0; k < 17 && k < mon_q.size(); k++) begin
         checks++;
         if (mon_q[k] !== 8'(8'h40 + k) || mon_stop_q[k] !== 1'b1) begin
            errors++;
            $display("FAIL tx_fill_byte%0d: got %h/stop %b expected %h/stop 1", k, mon_q[k], mon_stop_q[k], 8'(8'h40 + k));
         end
         if (k > 0) begin
            checks++;
            if (mon_t[k] - mon_t[k-1] != longint'(210)) begin
               errors++;
               $display("FAIL tx_back_to_back%0d: got %0d cycles expected 210", k, mon_t[k] - mon_t[k-1]);
            end
         end
      end
      bus_read(ADDR_TXCNT, 1, v);
      checks++;
      if (v !== 8'd0) begin errors++; $display("FAIL tx_count_drained: got %0d expected 0", v); end
   endtask

   task automatic test_loopback();
      logic [7:0] v;
      logic [7:0] exp_q[$];
      logic [7:0] b;
      bit         ok;
      int         n;
      loop_en = 1'b1;
      bus_write(ADDR_DATA, 8'hA5);
      wait_rx_count(1, 400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL loop_wait: got timeout expected RX_COUNT=1"); end
      bus_read(ADDR_DATA, 3, v);
      checks++;
      if (v !== 8'hA5) begin errors++; $display("FAIL loop_data: got %h expected a5", v); end
      bus_read(ADDR_RXCNT, 1, v);
      checks++;
      if (v !== 8'd0) begin errors++; $display("FAIL loop_rxcnt_after_pop: got %0d expected 0", v); end
      bus_read(ADDR_STATUS, 1, v);
      checks++;
      if (v[ST_RX_NOT_EMPTY] !== 1'b0) begin errors++; $display("FAIL loop_rx_not_empty: got %b expected 0", v[ST_RX_NOT_EMPTY]); end
      n = $urandom_range(3, 6);
      for (int k = 0; k < n; k++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         bus_write(ADDR_DATA, b);
      end
      wait_rx_count(n, n * 160 + 400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL loop_burst_wait: got timeout expected RX_COUNT=%0d", n); end
      for (int k = 0; k < n; k++) begin
         bus_read(ADDR_DATA, $urandom_range(1, 3), v);
         b = exp_q.pop_front();
         checks++;
         if (v !== b) begin errors++; $display("FAIL loop_burst_byte%0d: got %h expected %h", k, v, b); end
      end
      repeat (60) @(negedge clk);
      loop_en = 1'b0;
   endtask

   task automatic test_overrun();
      logic [7:0] v;
      logic [7:0] b;
      logic [7:0] exp_q[$];
      for (int k = 0; k < 17; k++) begin
         b = 8'($urandom);
         if (exp_q.size() < 16) exp_q.push_back(b);
         send_rx(b, 1'b1, 20);
      end
      repeat (5) @(negedge clk);
      bus_read(ADDR_RXCNT, 1, v);
      checks++;
      if (v !== 8'd16) begin errors++; $display("FAIL ovr_rxcnt: got %0d expected 16", v); end
      bus_read(ADDR_STATUS, 1, v);
      checks++;
      if (v[ST_RX_OVERRUN] !== 1'b1 || v[ST_FRAMING_ERR] !== 1'b0 || v[ST_RX_NOT_EMPTY] !== 1'b1) begin
         errors++; $display("FAIL ovr_status_set: got %h expected b3=1 b4=0 b1=1", v);
      end
      bus_read(ADDR_STATUS, 1, v);
      checks++;
      if (v[ST_RX_OVERRUN] !== 1'b0) begin errors++; $display("FAIL ovr_status_clear: got %b expected 0", v[ST_RX_OVERRUN]); end
      for (int k = 0; k < 16; k++) begin
         bus_read(ADDR_DATA, 1, v);
         b = exp_q.pop_front();
         checks++;
         if (v !== b) begin errors++; $display("FAIL ovr_byte%0d: got %h expected %h", k, v, b); end
      end
      bus_read(ADDR_RXCNT, 1, v);
      checks++;
      if (v !== 8'd0) begin errors++; $display("FAIL ovr_drained: got %0d expected 0", v); end
   endtask

   task automatic test_framing_glitch();
      logic [7:0] v;
      logic [7:0] b;
      send_rx(8'($urandom), 1'b0, 20);
      repeat (5) @(negedge clk);
      bus_read(ADDR_STATUS, 1, v);
      checks++;
      if (v[ST_FRAMING_ERR] !== 1'b1 || v[ST_RX_OVERRUN] !== 1'b0) begin
         errors++; $display("FAIL fe_set: got %h expected b4=1 b3=0", v);
      end
      bus_read(ADDR_RXCNT, 1, v);
      checks++;
      if (v !== 8'd0) begin errors++; $display("FAIL fe_rxcnt: got %0d expected 0", v); end
      bus_read(ADDR_STATUS, 1, v);
      checks++;
      if (v[ST_FRAMING_ERR] !== 1'b0) begin errors++; $display("FAIL fe_clear: got %b expected 0", v[ST_FRAMING_ERR]); end
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (6) @(negedge clk);
      rx_drv = 1'b1;
      repeat (80) @(negedge clk);
      bus_read(ADDR_RXCNT, 1, v);
      checks++;
      if (v !== 8'd0) begin errors++; $display("FAIL glitch_rxcnt: got %0d expected 0", v); end
      bus_read(ADDR_STATUS, 1, v);
      checks++;
      if ((v & 8'h1A) !== 8'h00) begin errors++; $display("FAIL glitch_flags: got %h expected b1,b3,b4=0", v); end
      b = 8'($urandom);
      send_rx(b, 1'b1, 20);
      bus_read(ADDR_DATA, 1, v);
      checks++;
      if (v !== b) begin errors++; $display("FAIL recover_byte: got %h expected %h", v, b); end
   endtask

   task automatic test_irq_div();
      logic [7:0] v;
      logic [7:0] b;
      bus_write(ADDR_IRQ_EN, 8'h01);
      repeat (2) @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
      b = 8'($urandom);
      send_rx(b, 1'b1, 20);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx: got %b expected 1", irq); end
      bus_read(ADDR_DATA, 1, v);
      checks++;
      if (v !== b) begin errors++; $display("FAIL irq_rx_byte: got %h expected %h", v, b); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_pop_same: got %b expected 1", irq); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_pop_next: got %b expected 0", irq); end
      bus_write(ADDR_IRQ_EN, 8'h02);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_txnf_same: got %b expected 0", irq); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_txnf_next: got %b expected 1", irq); end
      bus_write(ADDR_IRQ_EN, 8'h04);
      repeat (2) @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_err_idle: got %b expected 0", irq); end
      send_rx(8'($urandom), 1'b0, 20);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_err_set: got %b expected 1", irq); end
      bus_read(ADDR_STATUS, 1, v);
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_err_cleared: got %b expected 0", irq); end
      bus_write(ADDR_IRQ_EN, 8'h00);
      bus_write(ADDR_DIV_HI, 8'h00);
      bus_write(ADDR_DIV_LO, 8'h03);
      bus_read(ADDR_DIV_LO, 1, v);
      checks++;
      if (v !== 8'd15) begin errors++; $display("FAIL div_clamp_lo: got %0d expected 15", v); end
      bus_write(ADDR_DIV_HI, 8'h01);
      bus_read(ADDR_DIV_HI, 1, v);
      checks++;
      if (v !== 8'h01) begin errors++; $display("FAIL div_hi_rw: got %h expected 01", v); end
      bus_read(ADDR_DIV_LO, 1, v);
      checks++;
      if (v !== 8'h0F) begin errors++; $display("FAIL div_lo_keep: got %h expected 0f", v); end
      set_div(20);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] v;
      bus_write(ADDR_DATA, 8'h00);
      repeat (30) @(negedge clk);
      checks++;
      if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_low: got %b expected 0", uart_tx); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_abort: got %b expected 1", uart_tx); end
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(ADDR_STATUS, 1, v);
      checks++;
      if (v !== 8'h05) begin errors++; $display("FAIL midframe_status: got %h expected 05", v); end
      bus_read(ADDR_DIV_LO, 1, v);
      checks++;
      if (v !== 8'hDA) begin errors++; $display("FAIL midframe_div: got %h expected da", v); end
   endtask

   initial begin
      test_reset();
      test_tx_frame();
      test_tx_fill();
      test_loopback();
      test_overrun();
      test_framing_glitch();
      test_irq_div();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
